// File: rtl/riscv_pkg.sv
// Shared types for the ID/EX operand stage: widths, ALU op codes, the ID/EX register layout
// and the forwarding-match helper.
package riscv_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int OPCODE_LENGTH  = 4;
  localparam int PC_WIDTH       = 9;
  localparam int REG_ADDR_WIDTH = 5;

  typedef enum logic [OPCODE_LENGTH-1:0] {
    ALU_AND  = 4'b0000,
    ALU_XOR  = 4'b0001,
    ALU_SUB  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_ADD  = 4'b0100,
    ALU_BGE  = 4'b0101,
    ALU_BNE  = 4'b0110,
    ALU_SRAI = 4'b0111,
    ALU_EQ   = 4'b1000,
    ALU_SLLI = 4'b1001,
    ALU_LUI  = 4'b1010,
    ALU_SRLI = 4'b1100,
    ALU_BLT  = 4'b1101,
    ALU_SLT  = 4'b1110,
    ALU_J    = 4'b1111
  } alu_op_t;

  // An all-zero id_ex_t is a bubble.
  typedef struct packed {
    logic                      valid;
    logic                      reg_write;
    logic                      mem_read;
    logic                      mem_write;
    logic                      branch;
    logic                      alu_src;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    alu_op_t                   op;
    logic [PC_WIDTH-1:0]       pc4;
    logic [DATA_WIDTH-1:0]     rs1_data;
    logic [DATA_WIDTH-1:0]     rs2_data;
    logic [DATA_WIDTH-1:0]     imm;
  } id_ex_t;

  // x0 is hardwired to zero, so a writer targeting it never supplies a value.
  function automatic logic fwd_hit(
    input logic                      reg_write,
    input logic [REG_ADDR_WIDTH-1:0] rd,
    input logic [REG_ADDR_WIDTH-1:0] rs
  );
    return reg_write && (rd != '0) && (rd == rs);
  endfunction

endpackage

// File: rtl/id_ex_operand_stage_forward_mux.sv
// Operand forwarding select for one source register: EX/MEM beats MEM/WB beats the stored value.
// Purely combinational, no state.
module forward_mux #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] i_rs,
  input  logic [DATA_WIDTH-1:0]     i_stored,
  input  logic [REG_ADDR_WIDTH-1:0] i_exmem_rd,
  input  logic                      i_exmem_reg_write,
  input  logic [DATA_WIDTH-1:0]     i_exmem_result,
  input  logic [REG_ADDR_WIDTH-1:0] i_memwb_rd,
  input  logic                      i_memwb_reg_write,
  input  logic [DATA_WIDTH-1:0]     i_memwb_result,
  output logic [DATA_WIDTH-1:0]     o_data
);
  import riscv_pkg::fwd_hit;

  logic w_exmem_hit;
  logic w_memwb_hit;

  assign w_exmem_hit = fwd_hit(i_exmem_reg_write, i_exmem_rd, i_rs);
  assign w_memwb_hit = fwd_hit(i_memwb_reg_write, i_memwb_rd, i_rs);

  // The EX/MEM producer is younger, so its value is the architecturally current one.
  always_comb begin
    o_data = i_stored;
    if (w_exmem_hit) begin
      o_data = i_exmem_result;
    end else if (w_memwb_hit) begin
      o_data = i_memwb_result;
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with RAW forwarding and load-use bubble insertion, feeding the ALU.
// Operands valid 1 cycle after capture; stall freezes the register, load_use_stall holds IF/ID.
module id_ex_operand_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int OPCODE_LENGTH  = 4,
  parameter int PC_WIDTH       = 9,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd,
  input  logic [DATA_WIDTH-1:0]     id_rs1_data,
  input  logic [DATA_WIDTH-1:0]     id_rs2_data,
  input  logic [DATA_WIDTH-1:0]     id_imm,
  input  logic                      id_alu_src,
  input  logic [OPCODE_LENGTH-1:0]  id_operation,
  input  logic [PC_WIDTH-1:0]       id_pc,
  input  logic                      id_reg_write,
  input  logic                      id_mem_read,
  input  logic                      id_mem_write,
  input  logic                      id_branch,
  input  logic [REG_ADDR_WIDTH-1:0] exmem_rd,
  input  logic                      exmem_reg_write,
  input  logic [DATA_WIDTH-1:0]     exmem_result,
  input  logic [REG_ADDR_WIDTH-1:0] memwb_rd,
  input  logic                      memwb_reg_write,
  input  logic [DATA_WIDTH-1:0]     memwb_result,
  output logic [DATA_WIDTH-1:0]     SrcA,
  output logic [DATA_WIDTH-1:0]     SrcB,
  output logic [OPCODE_LENGTH-1:0]  Operation,
  output logic [PC_WIDTH-1:0]       Pc4,
  output logic                      ex_valid,
  output logic                      ex_reg_write,
  output logic                      ex_mem_read,
  output logic                      ex_mem_write,
  output logic                      ex_branch,
  output logic [REG_ADDR_WIDTH-1:0] ex_rd,
  output logic [DATA_WIDTH-1:0]     ex_store_data,
  output logic                      load_use_stall
);
  import riscv_pkg::id_ex_t;
  import riscv_pkg::alu_op_t;
  import riscv_pkg::fwd_hit;

  id_ex_t                r_ex;
  id_ex_t                w_next;
  logic                  w_load_use;
  logic                  w_capture;
  logic [DATA_WIDTH-1:0] w_rs1_wt;
  logic [DATA_WIDTH-1:0] w_rs2_wt;
  logic [DATA_WIDTH-1:0] w_fwd_a;
  logic [DATA_WIDTH-1:0] w_fwd_b;

  assign w_load_use = r_ex.valid && r_ex.mem_read && (r_ex.rd != '0) &&
                      ((r_ex.rd == id_rs1) || (r_ex.rd == id_rs2)) &&
                      id_valid && !flush;

  assign w_capture = id_valid && !flush && !w_load_use;

  // The register file is written at the end of this cycle, so its read data is stale for MEM/WB's rd.
  assign w_rs1_wt = fwd_hit(memwb_reg_write, memwb_rd, id_rs1) ? memwb_result : id_rs1_data;
  assign w_rs2_wt = fwd_hit(memwb_reg_write, memwb_rd, id_rs2) ? memwb_result : id_rs2_data;

  always_comb begin
    w_next = '0;
    if (w_capture) begin
      w_next.valid     = 1'b1;
      w_next.reg_write = id_reg_write;
      w_next.mem_read  = id_mem_read;
      w_next.mem_write = id_mem_write;
      w_next.branch    = id_branch;
      w_next.alu_src   = id_alu_src;
      w_next.rd        = id_rd;
      w_next.rs1       = id_rs1;
      w_next.rs2       = id_rs2;
      w_next.op        = alu_op_t'(id_operation);
      w_next.pc4       = id_pc + PC_WIDTH'(4);
      w_next.rs1_data  = w_rs1_wt;
      w_next.rs2_data  = w_rs2_wt;
      w_next.imm       = id_imm;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex <= '0;
    end else if (!stall) begin
      r_ex <= w_next;
    end
  end

  forward_mux #(
    .DATA_WIDTH     (DATA_WIDTH),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_fwd_a (
    .i_rs              (r_ex.rs1),
    .i_stored          (r_ex.rs1_data),
    .i_exmem_rd        (exmem_rd),
    .i_exmem_reg_write (exmem_reg_write),
    .i_exmem_result    (exmem_result),
    .i_memwb_rd        (memwb_rd),
    .i_memwb_reg_write (memwb_reg_write),
    .i_memwb_result    (memwb_result),
    .o_data            (w_fwd_a)
  );

  forward_mux #(
    .DATA_WIDTH     (DATA_WIDTH),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_fwd_b (
    .i_rs              (r_ex.rs2),
    .i_stored          (r_ex.rs2_data),
    .i_exmem_rd        (exmem_rd),
    .i_exmem_reg_write (exmem_reg_write),
    .i_exmem_result    (exmem_result),
    .i_memwb_rd        (memwb_rd),
    .i_memwb_reg_write (memwb_reg_write),
    .i_memwb_result    (memwb_result),
    .o_data            (w_fwd_b)
  );

  assign SrcA           = w_fwd_a;
  assign SrcB           = r_ex.alu_src ? r_ex.imm : w_fwd_b;
  assign ex_store_data  = w_fwd_b;
  assign Operation      = r_ex.op;
  assign Pc4            = r_ex.pc4;
  assign ex_valid       = r_ex.valid;
  assign ex_reg_write   = r_ex.reg_write;
  assign ex_mem_read    = r_ex.mem_read;
  assign ex_mem_write   = r_ex.mem_write;
  assign ex_branch      = r_ex.branch;
  assign ex_rd          = r_ex.rd;
  assign load_use_stall = w_load_use;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage: directed scenarios plus randomized traffic
// compared against an instruction-level reference model.
module tb_id_ex_operand_stage;

  localparam int DW = 32;
  localparam int OW = 4;
  localparam int PW = 9;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset, stall, flush, id_valid;
  logic [AW-1:0] id_rs1, id_rs2, id_rd;
  logic [DW-1:0] id_rs1_data, id_rs2_data, id_imm;
  logic          id_alu_src;
  logic [OW-1:0] id_operation;
  logic [PW-1:0] id_pc;
  logic          id_reg_write, id_mem_read, id_mem_write, id_branch;
  logic [AW-1:0] exmem_rd, memwb_rd;
  logic          exmem_reg_write, memwb_reg_write;
  logic [DW-1:0] exmem_result, memwb_result;
  logic [DW-1:0] SrcA, SrcB, ex_store_data;
  logic [OW-1:0] Operation;
  logic [PW-1:0] Pc4;
  logic          ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch;
  logic [AW-1:0] ex_rd;
  logic          load_use_stall;

  int errors = 0;
  int checks = 0;

  id_ex_operand_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_alu_src(id_alu_src), .id_operation(id_operation), .id_pc(id_pc),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_branch(id_branch),
    .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .exmem_result(exmem_result),
    .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .memwb_result(memwb_result),
    .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation), .Pc4(Pc4),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_branch(ex_branch), .ex_rd(ex_rd),
    .ex_store_data(ex_store_data), .load_use_stall(load_use_stall)
  );

  always #5 clk = ~clk;

  // Reference model: the instruction currently sitting in EX, as the ISA sees it.
  typedef struct {
    bit          valid, rw, mr, mw, br, alu_src;
    int unsigned rd, rs1, rs2, op, pc4;
    logic [31:0] a, b, imm;
  } instr_t;

  instr_t m;

  function automatic logic [31:0] regval_at_capture(int unsigned idx, logic [31:0] rf);
    if (idx != 0 && memwb_reg_write && memwb_rd == idx) return memwb_result;
    return rf;
  endfunction

  function automatic logic [31:0] resolve(int unsigned idx, logic [31:0] stored);
    if (idx != 0 && exmem_reg_write && exmem_rd == idx) return exmem_result;
    if (idx != 0 && memwb_reg_write && memwb_rd == idx) return memwb_result;
    return stored;
  endfunction

  function automatic bit model_load_use();
    return m.valid && m.mr && m.rd != 0 && (m.rd == id_rs1 || m.rd == id_rs2) &&
           id_valid && !flush;
  endfunction

  task automatic step();
    instr_t nxt;
    nxt = '{default: 0};
    if (reset) begin
      nxt = '{default: 0};
    end else if (stall) begin
      nxt = m;
    end else if (id_valid && !flush && !model_load_use()) begin
      nxt.valid = 1; nxt.rw = id_reg_write; nxt.mr = id_mem_read;
      nxt.mw = id_mem_write; nxt.br = id_branch; nxt.alu_src = id_alu_src;
      nxt.rd = id_rd; nxt.rs1 = id_rs1; nxt.rs2 = id_rs2; nxt.op = id_operation;
      nxt.pc4 = (int'(id_pc) + 4) % 512;
      nxt.a = regval_at_capture(id_rs1, id_rs1_data);
      nxt.b = regval_at_capture(id_rs2, id_rs2_data);
      nxt.imm = id_imm;
    end
    @(posedge clk);
    m = nxt;
    #1;
  endtask

  task automatic clear_fwd();
    exmem_rd = 0; exmem_reg_write = 0; exmem_result = 0;
    memwb_rd = 0; memwb_reg_write = 0; memwb_result = 0;
  endtask

  task automatic set_id(input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                        input logic [AW-1:0] rs2, input logic [DW-1:0] d1,
                        input logic [DW-1:0] d2, input logic [DW-1:0] imm,
                        input logic asrc, input logic [OW-1:0] op, input logic [PW-1:0] pc,
                        input logic rw, input logic mr, input logic mw);
    id_valid = 1; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2; id_rs1_data = d1;
    id_rs2_data = d2; id_imm = imm; id_alu_src = asrc; id_operation = op; id_pc = pc;
    id_reg_write = rw; id_mem_read = mr; id_mem_write = mw; id_branch = 0;
  endtask

  task automatic test_reset();
    reset = 1; stall = 0; flush = 0; clear_fwd();
    set_id(3, 1, 2, 5, 7, 0, 0, 4'b0100, 9'h010, 1, 0, 0);
    step(); step();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_ex_valid: got %0h want 0", ex_valid); end
    checks++; if (SrcA !== 32'h0) begin errors++; $display("FAIL reset_srca: got %0h want 0", SrcA); end
    checks++; if (SrcB !== 32'h0) begin errors++; $display("FAIL reset_srcb: got %0h want 0", SrcB); end
    checks++; if (Operation !== 4'h0) begin errors++; $display("FAIL reset_op: got %0h want 0", Operation); end
    checks++; if (Pc4 !== 9'h0) begin errors++; $display("FAIL reset_pc4: got %0h want 0", Pc4); end
    checks++; if ({ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_rd} !== 9'h0) begin
      errors++; $display("FAIL reset_ctrl: got %0h want 0", {ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_rd}); end
  endtask

  task automatic test_basic_add();
    reset = 0;
    step();
    checks++; if (SrcA !== 32'd5) begin errors++; $display("FAIL add_srca: got %0h want 5", SrcA); end
    checks++; if (SrcB !== 32'd7) begin errors++; $display("FAIL add_srcb: got %0h want 7", SrcB); end
    checks++; if (Operation !== 4'b0100) begin errors++; $display("FAIL add_op: got %0h want 4", Operation); end
    checks++; if (ex_valid !== 1'b1 || ex_rd !== 5'd3 || ex_reg_write !== 1'b1) begin
      errors++; $display("FAIL add_ctrl: got v=%0h rd=%0h rw=%0h want 1 3 1", ex_valid, ex_rd, ex_reg_write); end
    checks++; if (Pc4 !== 9'h014) begin errors++; $display("FAIL add_pc4: got %0h want 14", Pc4); end
  endtask

  task automatic test_forward_priority();
    id_valid = 0;
    exmem_rd = 1; exmem_reg_write = 1; exmem_result = 32'h10;
    memwb_rd = 1; memwb_reg_write = 1; memwb_result = 32'h20;
    #1;
    checks++; if (SrcA !== 32'h10) begin errors++; $display("FAIL fwd_exmem_wins: got %0h want 10", SrcA); end
    exmem_reg_write = 0; #1;
    checks++; if (SrcA !== 32'h20) begin errors++; $display("FAIL fwd_memwb: got %0h want 20", SrcA); end
    exmem_reg_write = 1; exmem_rd = 0; memwb_rd = 0; #1;
    checks++; if (SrcA !== 32'd5) begin errors++; $display("FAIL fwd_x0_ignored: got %0h want 5", SrcA); end
    exmem_rd = 2; #1;
    checks++; if (SrcB !== 32'h10 || ex_store_data !== 32'h10) begin
      errors++; $display("FAIL fwd_rs2: got srcb=%0h st=%0h want 10", SrcB, ex_store_data); end
    clear_fwd();
  endtask

  task automatic test_load_use();
    set_id(4, 1, 0, 32'h100, 0, 8, 1, 4'b0100, 9'h020, 1, 1, 0);
    step();
    checks++; if (ex_mem_read !== 1'b1 || ex_rd !== 5'd4) begin
      errors++; $display("FAIL lw_capture: got mr=%0h rd=%0h want 1 4", ex_mem_read, ex_rd); end
    set_id(6, 1, 4, 32'h100, 0, 0, 0, 4'b0100, 9'h024, 1, 0, 0);
    #1;
    checks++; if (load_use_stall !== 1'b1) begin errors++; $display("FAIL lu_detect: got %0h want 1", load_use_stall); end
    step();
    checks++; if (ex_valid !== 1'b0 || Operation !== 4'h0) begin
      errors++; $display("FAIL lu_bubble: got v=%0h op=%0h want 0 0", ex_valid, Operation); end
    checks++; if (load_use_stall !== 1'b0) begin errors++; $display("FAIL lu_single: got %0h want 0", load_use_stall); end
    memwb_rd = 4; memwb_reg_write = 1; memwb_result = 32'hAB;
    step();
    checks++; if (SrcB !== 32'hAB || ex_valid !== 1'b1) begin
      errors++; $display("FAIL lu_forward: got srcb=%0h v=%0h want ab 1", SrcB, ex_valid); end
    clear_fwd(); #1;
    checks++; if (SrcB !== 32'hAB) begin errors++; $display("FAIL lu_stored: got %0h want ab", SrcB); end
  endtask

  task automatic test_flush_stall();
    set_id(7, 1, 0, 32'h100, 0, 3, 1, 4'b0100, 9'h030, 1, 0, 0);
    flush = 1; step();
    checks++; if (ex_valid !== 1'b0 || Operation !== 4'h0 || SrcB !== 32'h0) begin
      errors++; $display("FAIL flush_bubble: got v=%0h op=%0h b=%0h want 0 0 0", ex_valid, Operation, SrcB); end
    flush = 0; step();
    set_id(9, 2, 2, 1, 1, 0, 0, 4'b0010, 9'h040, 1, 0, 0);
    flush = 1; stall = 1; step();
    checks++; if (ex_valid !== 1'b1 || Operation !== 4'b0100 || SrcB !== 32'd3 || ex_rd !== 5'd7) begin
      errors++; $display("FAIL flush_stall_hold: got v=%0h op=%0h b=%0h rd=%0h want 1 4 3 7", ex_valid, Operation, SrcB, ex_rd); end
    flush = 0; stall = 0;
  endtask

  task automatic test_srai_pc_wrap();
    set_id(8, 1, 0, 32'h80, 0, 32'd1026, 1, 4'b0111, 9'h1FC, 1, 0, 0);
    step();
    checks++; if (SrcB !== 32'd1026 || Operation !== 4'b0111) begin
      errors++; $display("FAIL srai: got b=%0d op=%0h want 1026 7", SrcB, Operation); end
    checks++; if (Pc4 !== 9'h000) begin errors++; $display("FAIL pc_wrap: got %0h want 0", Pc4); end
  endtask

  task automatic test_write_through();
    set_id(10, 5, 0, 32'h0, 0, 0, 0, 4'b0100, 9'h050, 1, 0, 0);
    memwb_rd = 5; memwb_reg_write = 1; memwb_result = 32'h55;
    step();
    clear_fwd(); #1;
    checks++; if (SrcA !== 32'h55) begin errors++; $display("FAIL write_through: got %0h want 55", SrcA); end
  endtask

  task automatic test_random();
    logic [31:0] ea, eb, esb;
    for (int i = 0; i < 400; i++) begin
      stall = ($urandom_range(0, 7) == 0); flush = ($urandom_range(0, 7) == 0);
      id_valid = ($urandom_range(0, 5) != 0);
      id_rs1 = AW'($urandom_range(0, 3)); id_rs2 = AW'($urandom_range(0, 3));
      id_rd = AW'($urandom_range(0, 3));
      id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
      id_alu_src = 1'($urandom); id_operation = OW'($urandom); id_pc = PW'($urandom);
      id_reg_write = 1'($urandom); id_mem_read = ($urandom_range(0, 2) == 0);
      id_mem_write = 1'($urandom); id_branch = 1'($urandom);
      exmem_rd = AW'($urandom_range(0, 3)); exmem_reg_write = 1'($urandom); exmem_result = $urandom;
      memwb_rd = AW'($urandom_range(0, 3)); memwb_reg_write = 1'($urandom); memwb_result = $urandom;
      #1;
      checks++; if (load_use_stall !== model_load_use()) begin
        errors++; $display("FAIL rnd_load_use[%0d]: got %0h want %0h", i, load_use_stall, model_load_use()); end
      step();
      ea = resolve(m.rs1, m.a); eb = resolve(m.rs2, m.b); esb = m.alu_src ? m.imm : eb;
      checks++; if (SrcA !== ea) begin errors++; $display("FAIL rnd_srca[%0d]: got %0h want %0h", i, SrcA, ea); end
      checks++; if (SrcB !== esb) begin errors++; $display("FAIL rnd_srcb[%0d]: got %0h want %0h", i, SrcB, esb); end
      checks++; if (ex_store_data !== eb) begin errors++; $display("FAIL rnd_store[%0d]: got %0h want %0h", i, ex_store_data, eb); end
      checks++; if (Operation !== OW'(m.op) || Pc4 !== PW'(m.pc4) || ex_rd !== AW'(m.rd)) begin
        errors++; $display("FAIL rnd_fields[%0d]: got op=%0h pc4=%0h rd=%0h want %0h %0h %0h", i, Operation, Pc4, ex_rd, m.op, m.pc4, m.rd); end
      checks++; if ({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch} !== {m.valid, m.rw, m.mr, m.mw, m.br}) begin
        errors++; $display("FAIL rnd_ctrl[%0d]: got %b want %b", i, {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch}, {m.valid, m.rw, m.mr, m.mw, m.br}); end
    end
    stall = 0; flush = 0;
  endtask

  initial begin
    m = '{default: 0};
    #2;
    test_reset();
    test_basic_add();
    test_forward_priority();
    test_load_use();
    test_flush_stall();
    test_srai_pc_wrap();
    test_write_through();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
